// File: rtl/rc4_word_sched.sv
// rc4_word_sched: sequences fetch, keystream XOR and write-back of a block of ciphertext words
module rc4_word_sched #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  num_words_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              src_req_o,
  output logic [LEN_W-1:0]  src_addr_o,
  input  logic              read_ready_i,
  input  logic [DATA_W-1:0] rc4_data_i,
  output logic              ks_req_o,
  input  logic              ks_valid_i,
  input  logic [7:0]        ks_byte_i,
  output logic              dst_write_o,
  output logic [LEN_W-1:0]  dst_addr_o,
  output logic [DATA_W-1:0] dst_data_o,
  input  logic              dst_ack_i
);
  localparam int NB = DATA_W / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, KEYS, WRITE, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, ks_q, ks_d, out_q, out_d;
  logic [KW-1:0] k_q, k_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ks_d    = ks_q;
    k_d     = k_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (num_words_i == '0) ? DONE : FETCH;
        cnt_d   = num_words_i;
        idx_d   = '0;
      end
      FETCH: if (read_ready_i) begin
        data_d  = rc4_data_i;
        k_d     = '0;
        state_d = KEYS;
      end
      KEYS: if (ks_valid_i) begin
        ks_d[8*k_q +: 8] = ks_byte_i;
        k_d = k_q + 1'b1;
        if (k_q == KW'(NB - 1)) begin
          // output register keeps the plaintext stable through the write and after the block
          out_d   = data_q ^ ks_d;
          state_d = WRITE;
        end
      end
      WRITE: state_d = dst_ack_i ? NEXT : WRITE;
      NEXT: begin
        state_d = (idx_q == cnt_q - 1'b1) ? DONE : FETCH;
        idx_d   = (idx_q == cnt_q - 1'b1) ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ks_q    <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ks_q    <= ks_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end
  assign busy_o      = (state_q == FETCH) || (state_q == KEYS) || (state_q == WRITE) || (state_q == NEXT);
  assign done_o      = state_q == DONE;
  assign src_req_o   = state_q == FETCH;
  assign ks_req_o    = state_q == KEYS;
  assign dst_write_o = state_q == WRITE;
  assign src_addr_o  = idx_q;
  assign dst_addr_o  = idx_q;
  assign dst_data_o  = out_q;
endmodule
